// File: rtl/extmem_pkg.sv
// Shared encodings for the external memory bus controller: FSM states,
// chip-select codes, requester identities and the cycle descriptor.
package extmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam logic [1:0] SEL_RAM1 = 2'd0;
    localparam logic [1:0] SEL_RAM2 = 2'd1;
    localparam logic [1:0] SEL_ROM  = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_VID = 1'b1
    } req_id_e;

    localparam int CNT_W = 8;

    typedef struct packed {
        req_id_e     owner;
        logic [18:0] addr;
        logic [1:0]  sel;
        logic        we;
        logic        uds;
        logic        lds;
        logic [15:0] wdata;
    } cycle_t;

    // A CPU cycle that must be refused without touching the bus.
    function automatic logic isBusError(input logic [1:0] sel, input logic we);
        return (sel == SEL_RSVD) || ((sel == SEL_ROM) && we);
    endfunction

endpackage

// File: rtl/extmem_arb.sv
// Two-way alternating arbiter between the CPU and the video fetch port.
// The grant is combinational; the last-grant flop moves only when a cycle is accepted.
module extmem_arb
    import extmem_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    cpu_req_i,
    input  logic    vid_req_i,
    input  logic    update_i,
    output req_id_e grant_o
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        grant_o = REQ_CPU;
        if (cpu_req_i && vid_req_i) begin
            grant_o = (last_q == REQ_CPU) ? REQ_VID : REQ_CPU;
        end else if (vid_req_i) begin
            grant_o = REQ_VID;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update_i) begin
            last_d = grant_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_CPU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/extmem_ctrl.sv
// External SRAM/ROM bus sequencer shared by the CPU and the video fetch port:
// drives chip selects, strobes and byte lanes and returns DTACK/BERR or a video ack.
module extmem_ctrl
    import extmem_pkg::*;
#(
    parameter int unsigned RAM_WAIT = 2,
    parameter int unsigned ROM_WAIT = 4
)
(
    input  logic        sysclk,
    input  logic        sysrst_n,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_sel,
    input  logic        cpu_we,
    input  logic        cpu_uds,
    input  logic        cpu_lds,
    input  logic [18:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_dtack,
    output logic        cpu_berr,
    input  logic        vid_req,
    input  logic [18:0] vid_addr,
    output logic        vid_ack,
    output logic [18:0] mem_addr,
    output logic [15:0] mem_dout,
    output logic        mem_doe,
    input  logic [15:0] mem_din,
    output logic        csram1_n,
    output logic        csram2_n,
    output logic        csrom_n,
    output logic        re_n,
    output logic        we_n,
    output logic        ub_n,
    output logic        lb_n
);

    state_e           state_q, state_d;
    cycle_t           cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rdata_q, rdata_d;

    req_id_e grant;
    cycle_t  reqCyc;
    logic    anyReq;
    logic    grantIsErr;
    logic    lastAccess;
    logic    memActive;
    logic    strobe;

    assign anyReq     = cpu_req | vid_req;
    assign lastAccess = (cnt_q == '0);

    extmem_arb u_arb (
        .clk_i     (sysclk),
        .rst_ni    (sysrst_n),
        .cpu_req_i (cpu_req),
        .vid_req_i (vid_req),
        .update_i  ((state_q == ST_IDLE) && anyReq),
        .grant_o   (grant)
    );

    // Video fetches are always two-lane RAM1 reads regardless of CPU inputs.
    always_comb begin
        reqCyc       = '0;
        reqCyc.owner = grant;
        if (grant == REQ_VID) begin
            reqCyc.addr  = vid_addr;
            reqCyc.sel   = SEL_RAM1;
            reqCyc.we    = 1'b0;
            reqCyc.uds   = 1'b1;
            reqCyc.lds   = 1'b1;
            reqCyc.wdata = '0;
        end else begin
            reqCyc.addr  = cpu_addr;
            reqCyc.sel   = cpu_sel;
            reqCyc.we    = cpu_we;
            reqCyc.uds   = cpu_uds;
            reqCyc.lds   = cpu_lds;
            reqCyc.wdata = cpu_wdata;
        end
    end

    assign grantIsErr = (grant == REQ_CPU) && isBusError(cpu_sel, cpu_we);

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    state_d = grantIsErr ? ST_ERR : ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (lastAccess) begin
                    state_d = ST_HOLD;
                end
            end
            // A CPU that has already let go gets no DTACK.
            ST_HOLD: begin
                state_d = ((cyc_q.owner == REQ_CPU) && cpu_req) ? ST_DONE : ST_IDLE;
            end
            ST_DONE, ST_ERR: begin
                if (!cpu_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        memActive = (state_q == ST_SETUP) || (state_q == ST_ACCESS) || (state_q == ST_HOLD);
        strobe    = (state_q == ST_ACCESS);
        csram1_n  = !(memActive && (cyc_q.sel == SEL_RAM1));
        csram2_n  = !(memActive && (cyc_q.sel == SEL_RAM2));
        csrom_n   = !(memActive && (cyc_q.sel == SEL_ROM));
        re_n      = !(strobe && !cyc_q.we);
        we_n      = !(strobe && cyc_q.we);
        ub_n      = !(memActive && cyc_q.uds);
        lb_n      = !(memActive && cyc_q.lds);
        mem_doe   = memActive && cyc_q.we;
        cpu_dtack = (state_q == ST_DONE);
        cpu_berr  = (state_q == ST_ERR);
        vid_ack   = (state_q == ST_HOLD) && (cyc_q.owner == REQ_VID);
    end

    // Strobe width counter is armed in SETUP; read data is captured on the last strobe cycle.
    always_comb begin
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    cyc_d = reqCyc;
                end
            end
            ST_SETUP: begin
                cnt_d = (cyc_q.sel == SEL_ROM) ? CNT_W'(ROM_WAIT) : CNT_W'(RAM_WAIT);
            end
            ST_ACCESS: begin
                if (!lastAccess) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!cyc_q.we) begin
                    rdata_d = mem_din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            cyc_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign mem_addr  = cyc_q.addr;
    assign mem_dout  = cyc_q.wdata;

endmodule

// File: tb/tb_extmem_ctrl.sv
// Self-checking bench for extmem_ctrl: directed bus-timing scenarios followed by
// randomized CPU/video traffic, all checked every cycle against a transaction-level model.
module tb_extmem_ctrl;

    localparam int RAM_WAIT = 2;
    localparam int ROM_WAIT = 4;

    logic        sysclk = 1'b0;
    logic        sysrst_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic [1:0]  cpu_sel = 2'd0;
    logic        cpu_we = 1'b0;
    logic        cpu_uds = 1'b0;
    logic        cpu_lds = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_dtack, cpu_berr;
    logic        vid_req = 1'b0;
    logic [18:0] vid_addr = '0;
    logic        vid_ack;
    logic [18:0] mem_addr;
    logic [15:0] mem_dout;
    logic        mem_doe;
    logic [15:0] mem_din = '0;
    logic        csram1_n, csram2_n, csrom_n, re_n, we_n, ub_n, lb_n;

    extmem_ctrl #(.RAM_WAIT(RAM_WAIT), .ROM_WAIT(ROM_WAIT)) dut (
        .sysclk(sysclk), .sysrst_n(sysrst_n),
        .cpu_req(cpu_req), .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_dtack(cpu_dtack), .cpu_berr(cpu_berr),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_doe(mem_doe), .mem_din(mem_din),
        .csram1_n(csram1_n), .csram2_n(csram2_n), .csrom_n(csrom_n),
        .re_n(re_n), .we_n(we_n), .ub_n(ub_n), .lb_n(lb_n)
    );

    always #5 sysclk = ~sysclk;

    int  checks = 0;
    int  errors = 0;
    bit  cmpEn = 1'b0;
    bit  stimDone = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: mode 0 idle, 1 bus cycle (phase counts cycles since grant),
    // 2 waiting for CPU to release after DTACK, 3 bus error.
    int          mMode = 0;
    int          mPh = 0;
    int          mW = 0;
    logic        mWho = 1'b0;
    logic        mLast = 1'b0;
    logic [1:0]  mSel = 2'd0;
    logic        mWe = 1'b0, mUds = 1'b0, mLds = 1'b0;
    logic [18:0] mAddr = '0;
    logic [15:0] mWdata = '0, mRdata = '0;

    function automatic logic pickVideo(input logic c, input logic v, input logic last);
        if (c && v) return !last;
        return v;
    endfunction

    always @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            mMode  <= 0;
            mPh    <= 0;
            mLast  <= 1'b0;
            mAddr  <= '0;
            mRdata <= '0;
            mSel   <= 2'd0;
            mWe    <= 1'b0;
            mUds   <= 1'b0;
            mLds   <= 1'b0;
            mWho   <= 1'b0;
        end else begin
            case (mMode)
                0: if (cpu_req || vid_req) begin
                    mPh <= 1;
                    if (pickVideo(cpu_req, vid_req, mLast)) begin
                        mWho <= 1'b1; mLast <= 1'b1; mSel <= 2'd0; mWe <= 1'b0;
                        mUds <= 1'b1; mLds <= 1'b1; mAddr <= vid_addr;
                        mW <= RAM_WAIT + 1; mMode <= 1;
                    end else begin
                        mWho <= 1'b0; mLast <= 1'b0; mSel <= cpu_sel; mWe <= cpu_we;
                        mUds <= cpu_uds; mLds <= cpu_lds; mAddr <= cpu_addr; mWdata <= cpu_wdata;
                        mW <= ((cpu_sel == 2'd2) ? ROM_WAIT : RAM_WAIT) + 1;
                        mMode <= ((cpu_sel == 2'd3) || (cpu_sel == 2'd2 && cpu_we)) ? 3 : 1;
                    end
                end
                1: begin
                    if (mPh == mW + 1 && !mWe) mRdata <= mem_din;
                    if (mPh == mW + 2) mMode <= (!mWho && cpu_req) ? 2 : 0;
                    mPh <= mPh + 1;
                end
                default: if (!cpu_req) mMode <= 0;
            endcase
        end
    end

    logic eBus, eStrobe;
    assign eBus    = (mMode == 1);
    assign eStrobe = eBus && (mPh >= 2) && (mPh <= mW + 1);

    always @(negedge sysclk) begin
        if (cmpEn && sysrst_n === 1'b1) begin
            checkOutput("csram1_n", csram1_n, !(eBus && mSel == 2'd0));
            checkOutput("csram2_n", csram2_n, !(eBus && mSel == 2'd1));
            checkOutput("csrom_n", csrom_n, !(eBus && mSel == 2'd2));
            checkOutput("re_n", re_n, !(eStrobe && !mWe));
            checkOutput("we_n", we_n, !(eStrobe && mWe));
            checkOutput("ub_n", ub_n, !(eBus && mUds));
            checkOutput("lb_n", lb_n, !(eBus && mLds));
            checkOutput("mem_doe", mem_doe, eBus && mWe);
            if (eBus && mWe) checkOutput("mem_dout", mem_dout, mWdata);
            checkOutput("cpu_dtack", cpu_dtack, mMode == 2);
            checkOutput("cpu_berr", cpu_berr, mMode == 3);
            checkOutput("vid_ack", vid_ack, eBus && mWho && (mPh == mW + 2));
            checkOutput("cpu_rdata", cpu_rdata, mRdata);
            checkOutput("mem_addr", mem_addr, mAddr);
            checkOutput("cs_overlap", $countones({csram1_n, csram2_n, csrom_n}) < 2, 1'b0);
            checkOutput("re_we_overlap", !re_n && !we_n, 1'b0);
        end
    end

    int   nCs1, nCs2, nRom, nRe, nWe, nUb, nLb, nDoe, nDtack, nBerr, nAck, firstDtack, firstAck;
    logic [15:0] lastDout;

    task automatic observe(input int n);
        nCs1 = 0; nCs2 = 0; nRom = 0; nRe = 0; nWe = 0; nUb = 0; nLb = 0; nDoe = 0;
        nDtack = 0; nBerr = 0; nAck = 0; firstDtack = -1; firstAck = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            if (!csram1_n) nCs1++;
            if (!csram2_n) nCs2++;
            if (!csrom_n) nRom++;
            if (!re_n) nRe++;
            if (!we_n) nWe++;
            if (!ub_n) nUb++;
            if (!lb_n) nLb++;
            if (mem_doe) begin nDoe++; lastDout = mem_dout; end
            if (cpu_berr) nBerr++;
            if (cpu_dtack) begin nDtack++; if (firstDtack < 0) firstDtack = i; end
            if (vid_ack) begin nAck++; if (firstAck < 0) firstAck = i; end
        end
    endtask

    task automatic applyStimulus(input logic cReq, input logic [1:0] sel, input logic we,
                                 input logic uds, input logic lds, input logic [18:0] addr,
                                 input logic [15:0] wdata, input logic vReq, input logic [18:0] vAddr);
        @(posedge sysclk);
        #1;
        cpu_req = cReq; cpu_sel = sel; cpu_we = we; cpu_uds = uds; cpu_lds = lds;
        cpu_addr = addr; cpu_wdata = wdata; vid_req = vReq; vid_addr = vAddr;
    endtask

    task automatic releaseAll(input string name);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        observe(2);
        checkOutput({name, "_released_dtack"}, cpu_dtack, 1'b0);
        checkOutput({name, "_released_berr"}, cpu_berr, 1'b0);
    endtask

    task automatic cpuRandom(input int n);
        for (int t = 0; t < n; t++) begin
            logic [1:0] lanes;
            int         k;
            repeat ($urandom_range(0, 3)) @(posedge sysclk);
            @(posedge sysclk);
            #1;
            lanes     = 2'($urandom_range(1, 3));
            cpu_sel   = 2'($urandom_range(0, 3));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_uds   = lanes[1];
            cpu_lds   = lanes[0];
            cpu_addr  = 19'($urandom);
            cpu_wdata = 16'($urandom);
            cpu_req   = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 8)) @(posedge sysclk);
                #1;
                cpu_req = 1'b0;
            end else begin
                k = 0;
                do begin
                    @(negedge sysclk);
                    k++;
                end while (!(cpu_dtack || cpu_berr) && k < 200);
                checkOutput("cpu_handshake_timeout", cpu_dtack || cpu_berr, 1'b1);
                repeat ($urandom_range(0, 2)) @(posedge sysclk);
                @(posedge sysclk);
                #1;
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic vidRandom(input int n);
        for (int t = 0; t < n; t++) begin
            int k;
            repeat ($urandom_range(0, 4)) @(posedge sysclk);
            @(posedge sysclk);
            #1;
            vid_addr = 19'($urandom);
            vid_req  = 1'b1;
            k = 0;
            do begin
                @(negedge sysclk);
                k++;
            end while (!vid_ack && k < 200);
            checkOutput("vid_ack_timeout", vid_ack, 1'b1);
            @(posedge sysclk);
            #1;
            vid_req = 1'b0;
        end
    endtask

    task automatic dinRandom();
        while (!stimDone) begin
            @(posedge sysclk);
            #1;
            mem_din = 16'($urandom);
        end
    endtask

    initial begin
        #2 sysrst_n = 1'b0;
        repeat (3) @(posedge sysclk);
        #3 sysrst_n = 1'b1;
        cmpEn = 1'b1;
        @(negedge sysclk);
        checkOutput("reset_cs", {csram1_n, csram2_n, csrom_n}, 3'b111);
        checkOutput("reset_strobes", {re_n, we_n, ub_n, lb_n}, 4'b1111);
        checkOutput("reset_acks", {mem_doe, cpu_dtack, cpu_berr, vid_ack}, 4'b0000);
        checkOutput("reset_rdata", cpu_rdata, 16'h0000);
        checkOutput("reset_addr", mem_addr, 19'h00000);

        $display("[TB] CPU RAM1 read");
        mem_din = 16'hBEEF;
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 19'h00123, 16'h0000, 1'b0, '0);
        observe(10);
        checkOutput("ram1rd_cs_width", nCs1, 5);
        checkOutput("ram1rd_re_width", nRe, 3);
        checkOutput("ram1rd_we_width", nWe, 0);
        checkOutput("ram1rd_dtack_cycle", firstDtack, 6);
        checkOutput("ram1rd_rdata", cpu_rdata, 16'hBEEF);
        checkOutput("ram1rd_addr", mem_addr, 19'h00123);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        observe(1);
        checkOutput("ram1rd_dtack_drop_cycle", nDtack, 1);
        observe(1);
        checkOutput("ram1rd_dtack_cleared", nDtack, 0);

        $display("[TB] CPU RAM2 lower-byte write");
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 19'h004AB, 16'h00A5, 1'b0, '0);
        observe(7);
        checkOutput("ram2wr_we_width", nWe, 3);
        checkOutput("ram2wr_re_width", nRe, 0);
        checkOutput("ram2wr_lb", nLb, 5);
        checkOutput("ram2wr_ub", nUb, 0);
        checkOutput("ram2wr_doe", nDoe, 5);
        checkOutput("ram2wr_cs2", nCs2, 5);
        checkOutput("ram2wr_dout", lastDout, 16'h00A5);
        checkOutput("ram2wr_dtack_cycle", firstDtack, 6);
        releaseAll("ram2wr");

        $display("[TB] CPU ROM read");
        mem_din = 16'h1234;
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 19'h40000, 16'h0000, 1'b0, '0);
        observe(10);
        checkOutput("romrd_re_width", nRe, 5);
        checkOutput("romrd_cs_width", nRom, 7);
        checkOutput("romrd_dtack_cycle", firstDtack, 8);
        checkOutput("romrd_rdata", cpu_rdata, 16'h1234);
        releaseAll("romrd");

        $display("[TB] CPU ROM write and reserved select");
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 19'h40010, 16'hFFFF, 1'b0, '0);
        observe(6);
        checkOutput("romwr_berr", nBerr, 5);
        checkOutput("romwr_no_cs", nCs1 + nCs2 + nRom, 0);
        checkOutput("romwr_no_strobe", nRe + nWe + nDoe, 0);
        releaseAll("romwr");
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 19'h12345, 16'h0000, 1'b0, '0);
        observe(4);
        checkOutput("sel3_berr", nBerr, 3);
        checkOutput("sel3_no_bus", nCs1 + nCs2 + nRom + nRe + nWe, 0);
        releaseAll("sel3");

        $display("[TB] simultaneous CPU and video");
        mem_din = 16'hCAFE;
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 19'h7FFFF, 16'h0000, 1'b1, 19'h00042);
        observe(13);
        checkOutput("simul_video_first_ack", firstAck, 5);
        checkOutput("simul_ack_pulse", nAck, 1);
        checkOutput("simul_cpu_dtack", firstDtack, 12);
        checkOutput("simul_cs1", nCs1, 5);
        checkOutput("simul_cs2", nCs2, 5);
        releaseAll("simul");

        $display("[TB] reset during video access");
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 19'h00100);
        observe(3);
        checkOutput("rstmid_re_before", re_n, 1'b0);
        #2 sysrst_n = 1'b0;
        vid_req = 1'b0;
        #1;
        checkOutput("rstmid_re_async", re_n, 1'b1);
        checkOutput("rstmid_cs_async", {csram1_n, csram2_n, csrom_n}, 3'b111);
        checkOutput("rstmid_addr_async", mem_addr, 19'h00000);
        @(posedge sysclk);
        #3 sysrst_n = 1'b1;
        observe(8);
        checkOutput("rstmid_no_ack", nAck + nDtack, 0);
        checkOutput("rstmid_no_bus", nCs1 + nRe, 0);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 19'h00055, 16'h0000, 1'b1, 19'h00066);
        observe(13);
        checkOutput("rstmid_fresh_video_first", firstAck, 5);
        checkOutput("rstmid_fresh_dtack", firstDtack, 12);
        releaseAll("rstmid");

        $display("[TB] CPU withdraws during access");
        mem_din = 16'h0F0F;
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 19'h00321, 16'h0000, 1'b0, '0);
        observe(2);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 19'h00777);
        observe(5);
        checkOutput("withdraw_re_width", nRe, 3);
        checkOutput("withdraw_no_dtack", nDtack, 0);
        observe(5);
        checkOutput("withdraw_vid_ack", firstAck, 4);
        checkOutput("withdraw_vid_re", nRe, 3);
        checkOutput("withdraw_still_no_dtack", nDtack, 0);
        releaseAll("withdraw");

        $display("[TB] randomized traffic");
        fork
            begin
                fork
                    cpuRandom(150);
                    vidRandom(150);
                join
                stimDone = 1'b1;
            end
            dinRandom();
        join
        releaseAll("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
